// File: rtl/uart_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// uart_fifo_ctrl
//   Memory-mapped UART controller. CPU stores are queued in a TX FIFO and fed
//   to serialTX one byte at a time by a small FSM. Bytes from serialRX are
//   queued in an RX FIFO and popped when the CPU reads the UART word. An RX
//   overflow sets a sticky overrun flag.
//
// Ports
//   clk, rst          system clock; asynchronous active-high reset
//   sel, rd           UART word selected / CPU load strobe
//   wmask, wdata      CPU store byte mask and data
//   rdata             registered read data (status + RX head byte)
//   tx_data, txmit    byte and one-cycle start pulse to serialTX
//   tx_busy, tx_done  serialTX handshake
//   rx_data, rx_rcv   byte and byte-valid pulse from serialRX
//   rx_irq            RX FIFO non-empty and RX interrupt enabled
//
// Read layout: [7:0] RX head, [8] tx_ready, [9] rx_valid, [10] overrun,
//              [11] tx_idle, [12] rx_ie, [19:16] RX count (saturates at 15)
// ----------------------------------------------------------------------------
module uart_fifo_ctrl #(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        rd,
  input  logic [3:0]  wmask,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        txmit,
  input  logic        tx_busy,
  input  logic        tx_done,
  input  logic [7:0]  rx_data,
  input  logic        rx_rcv,
  output logic        rx_irq
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [7:0]     r_tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] r_tx_wr, r_tx_rd;
  logic [TX_AW:0]   r_tx_cnt;
  logic [7:0]     r_rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] r_rx_wr, r_rx_rd;
  logic [RX_AW:0]   r_rx_cnt;

  logic        r_overrun;
  logic        r_rx_ie;
  logic [7:0]  r_tx_data;

  logic        w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
  logic        w_rx_full, w_rx_empty, w_rx_push, w_rx_pop, w_rx_ovf;
  logic        w_tx_idle;
  logic [7:0]  w_rx_head;
  logic [31:0] w_rx_cnt_ext;
  logic [3:0]  w_rx_cnt_sat;
  logic [31:0] w_status;
  logic        w_unused;

  assign w_tx_full  = (r_tx_cnt == (TX_AW+1)'(TX_DEPTH));
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == (RX_AW+1)'(RX_DEPTH));
  assign w_rx_empty = (r_rx_cnt == '0);

  // A write that lands while the FSM drains an entry still fits.
  assign w_tx_push = sel & wmask[0] & (~w_tx_full | w_tx_pop);
  assign w_rx_pop  = sel & rd & ~w_rx_empty;
  assign w_rx_push = rx_rcv & (~w_rx_full | w_rx_pop);
  assign w_rx_ovf  = rx_rcv & w_rx_full & ~w_rx_pop;

  // Byte lanes 1 and 2 and the unused control bits carry no function.
  assign w_unused = &{1'b0, wmask[2:1], wdata[23:8], wdata[31:26]};

  // NOTE: FIFO storage has no reset; the pointers and counts define validity,
  // so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= wdata[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wr] <= rx_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_wr  <= '0;
      r_tx_rd  <= '0;
      r_tx_cnt <= '0;
      r_rx_wr  <= '0;
      r_rx_rd  <= '0;
      r_rx_cnt <= '0;
    end else begin
      // Depths are powers of two, so pointers wrap by natural overflow.
      if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
        2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
      if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
        2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  // Control bits: a new overflow in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun <= 1'b0;
      r_rx_ie   <= 1'b0;
    end else begin
      if (sel & wmask[3]) begin
        r_rx_ie <= wdata[25];
        if (wdata[24]) r_overrun <= 1'b0;
      end
      if (w_rx_ovf) r_overrun <= 1'b1;
    end
  end

  // Status word, sampled before this cycle's pop.
  always_comb begin
    w_rx_head    = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rd];
    w_rx_cnt_ext = 32'(r_rx_cnt);
    w_rx_cnt_sat = (w_rx_cnt_ext > 32'd15) ? 4'hF : w_rx_cnt_ext[3:0];
    w_tx_idle    = w_tx_empty & (r_state == S_IDLE);
    w_status     = {12'h000, w_rx_cnt_sat, 3'b000, r_rx_ie, w_tx_idle,
                    r_overrun, ~w_rx_empty, ~w_tx_full, w_rx_head};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else if (sel & rd) rdata <= w_status;
  end

  // TX sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tx_data <= 8'h00;
    end else begin
      r_state <= w_next;
      if (w_tx_pop) r_tx_data <= r_tx_mem[r_tx_rd];
    end
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next   = r_state;
    w_tx_pop = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (~w_tx_empty) begin
          w_tx_pop = 1'b1;
          w_next   = S_START;
        end
      end
      S_START:     w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: if (tx_busy) w_next = S_WAIT_DONE;
      // Leaving on !tx_busy as well guards against a missed done pulse.
      S_WAIT_DONE: if (tx_done | ~tx_busy) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  assign txmit   = (r_state == S_START);
  assign tx_data = r_tx_data;
  assign rx_irq  = ~w_rx_empty & r_rx_ie;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
module tb_uart_fifo_ctrl;

  localparam int TXD   = 8;
  localparam int RXD   = 8;
  localparam int FRAME = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        rd = 1'b0;
  logic [3:0]  wmask = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        txmit;
  logic        tx_busy = 1'b0;
  logic        tx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_rcv = 1'b0;
  logic        rx_irq;

  uart_fifo_ctrl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk(clk), .rst(rst), .sel(sel), .rd(rd), .wmask(wmask), .wdata(wdata),
    .rdata(rdata), .tx_data(tx_data), .txmit(txmit), .tx_busy(tx_busy),
    .tx_done(tx_done), .rx_data(rx_data), .rx_rcv(rx_rcv), .rx_irq(rx_irq)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- serialTX stand-in (not reset by rst) ----------------
  bit         stall = 1'b0;
  int         env_cnt = 0;
  int         cyc = 0;
  int         last_done_cyc = -100;
  logic [7:0] sent_q[$];

  always @(negedge clk) begin
    cyc++;
    tx_done = 1'b0;
    if (txmit === 1'b1) begin
      if (sent_q.size() > 0)
        check("txmit_gap", 32'(cyc - last_done_cyc >= 2), 32'd1);
      sent_q.push_back(tx_data);
      tx_busy = 1'b1;
      env_cnt = FRAME;
    end else if (tx_busy && !stall) begin
      if (env_cnt > 1) env_cnt--;
      else begin
        tx_busy = 1'b0;
        tx_done = 1'b1;
        last_done_cyc = cyc;
      end
    end
  end

  // ---------------- behavioural model ----------------
  logic [7:0]  m_tx_q[$];
  logic [7:0]  m_rx_q[$];
  bit          m_owned, m_due, m_seen_busy, m_overrun, m_rx_ie;
  logic [7:0]  m_byte;
  logic [31:0] m_rdata;

  always @(posedge clk or posedge rst) begin : model
    bit rd_fire, rx_pop, tx_pop, tx_acc;
    logic [31:0] st;
    if (rst) begin
      m_tx_q.delete();
      m_rx_q.delete();
      m_owned = 0; m_due = 0; m_seen_busy = 0;
      m_overrun = 0; m_rx_ie = 0; m_byte = 8'h00; m_rdata = 32'h0;
    end else begin
      rd_fire = sel && rd;
      st = 32'h0;
      if (m_rx_q.size() > 0) st[7:0] = m_rx_q[0];
      st[8]     = m_tx_q.size() < TXD;
      st[9]     = m_rx_q.size() > 0;
      st[10]    = m_overrun;
      st[11]    = (m_tx_q.size() == 0) && !m_owned;
      st[12]    = m_rx_ie;
      st[19:16] = (m_rx_q.size() > 15) ? 4'd15 : 4'(m_rx_q.size());
      rx_pop = rd_fire && m_rx_q.size() > 0;
      tx_pop = !m_owned && m_tx_q.size() > 0;
      tx_acc = sel && wmask[0] && (m_tx_q.size() < TXD || tx_pop);
      if (rd_fire) m_rdata = st;
      if (rx_pop) void'(m_rx_q.pop_front());
      if (sel && wmask[3]) begin
        m_rx_ie = wdata[25];
        if (wdata[24]) m_overrun = 0;
      end
      if (rx_rcv) begin
        if (m_rx_q.size() < RXD) m_rx_q.push_back(rx_data);
        else m_overrun = 1;
      end
      // A byte is owned from its pop until serialTX has been seen busy and
      // then finishes; the start pulse occupies the first owned cycle.
      if (m_due) m_due = 0;
      else if (m_owned) begin
        if (!m_seen_busy) begin
          if (tx_busy) m_seen_busy = 1;
        end else if (tx_done || !tx_busy) m_owned = 0;
      end
      if (tx_pop) begin
        m_byte = m_tx_q.pop_front();
        m_owned = 1; m_due = 1; m_seen_busy = 0;
      end
      if (tx_acc) m_tx_q.push_back(wdata[7:0]);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("rdata", rdata, m_rdata);
      check("txmit", 32'(txmit), 32'(m_due));
      check("rx_irq", 32'(rx_irq), 32'(m_rx_q.size() > 0 && m_rx_ie));
      if (m_owned) check("tx_data", 32'(tx_data), 32'(m_byte));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    @(negedge clk);
    sel = 0; rd = 0; wmask = 4'h0; wdata = 32'h0; rx_rcv = 0;
  endtask

  task automatic wr(input logic [3:0] m, input logic [31:0] d);
    @(negedge clk);
    sel = 1; rd = 0; wmask = m; wdata = d;
  endtask

  task automatic do_read(output logic [31:0] v);
    @(negedge clk);
    sel = 1; rd = 1; wmask = 4'h0;
    idle();
    v = rdata;
  endtask

  task automatic rx_inject(input logic [7:0] b);
    @(negedge clk);
    rx_rcv = 1; rx_data = b;
    idle();
  endtask

  task automatic wait_sent(input int n, input int budget);
    int k = 0;
    while ((sent_q.size() < n || m_owned || m_tx_q.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("tx_drained", 32'(sent_q.size() >= n && !m_owned), 32'd1);
  endtask

  logic [31:0] v;
  int n_before;

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    check("rst_rdata", rdata, 32'h0);
    check("rst_txmit", 32'(txmit), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_rx_irq", 32'(rx_irq), 32'd0);

    do_read(v);
    check("reset_status", v, 32'h0000_0900);

    // Three back-to-back bytes
    wr(4'b0001, 32'h41); wr(4'b0001, 32'h42); wr(4'b0001, 32'h43); idle();
    wait_sent(3, 300);
    check("tx_byte0", 32'(sent_q[0]), 32'h41);
    check("tx_byte1", 32'(sent_q[1]), 32'h42);
    check("tx_byte2", 32'(sent_q[2]), 32'h43);
    do_read(v);
    check("tx_idle_after", v, 32'h0000_0900);

    // Overfill TX while serialTX is stalled busy
    stall = 1;
    for (int i = 0; i < 10; i++) wr(4'b0001, 32'h10 + 32'(i));
    idle();
    do_read(v);
    check("tx_full_status", v, 32'h0000_0000);
    stall = 0;
    wait_sent(12, 600);
    repeat (20) @(negedge clk);
    check("tx_sent_total", 32'(sent_q.size()), 32'd12);
    for (int i = 0; i < 9; i++) check("tx_fill_byte", 32'(sent_q[3 + i]), 32'h10 + 32'(i));

    // RX pop-on-read
    rx_inject(8'h55); rx_inject(8'hAA);
    do_read(v); check("rx_read1", v, 32'h0002_0B55);
    do_read(v); check("rx_read2", v, 32'h0001_0BAA);
    do_read(v); check("rx_read3", v, 32'h0000_0900);

    // RX overrun, clear, and full-with-pop
    for (int i = 0; i < 9; i++) rx_inject(8'h60 + 8'(i));
    do_read(v); check("rx_overrun", v, 32'h0008_0F60);
    rx_inject(8'h69);
    wr(4'b1000, 32'h0100_0000); idle();
    @(negedge clk);
    sel = 1; rd = 1; wmask = 4'h0; rx_rcv = 1; rx_data = 8'h77;
    idle();
    check("rx_full_pop", rdata, 32'h0008_0B61);
    do_read(v); check("rx_count_kept", v, 32'h0008_0B62);
    for (int i = 0; i < 7; i++) do_read(v);
    check("rx_last", v, 32'h0001_0B77);

    // RX interrupt
    wr(4'b1000, 32'h0200_0000); idle();
    check("irq_empty", 32'(rx_irq), 32'd0);
    rx_inject(8'h33);
    check("irq_set", 32'(rx_irq), 32'd1);
    do_read(v);
    check("irq_read", v, 32'h0001_1B33);
    check("irq_clear", 32'(rx_irq), 32'd0);

    // Reset while waiting for tx_done
    stall = 1;
    wr(4'b0001, 32'hC0); wr(4'b0001, 32'hC1); idle();
    repeat (6) @(negedge clk);
    check("mid_sent", 32'(sent_q[sent_q.size() - 1]), 32'hC0);
    n_before = sent_q.size();
    rst = 1;
    @(negedge clk);
    check("txmit_in_reset", 32'(txmit), 32'd0);
    @(negedge clk);
    rst = 0;
    stall = 0;
    repeat (30) @(negedge clk);
    check("no_tx_after_rst", 32'(sent_q.size()), 32'(n_before));
    do_read(v);
    check("status_after_rst", v, 32'h0000_0900);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
